// File: rtl/code_memory_bist_master_pkg.sv
// Shared encodings for the code-memory BIST master: FSM state values and the
// address rotation applied when building the test pattern.
package code_memory_bist_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int unsigned PAT_ROT = 7;

endpackage

// File: rtl/code_memory_bist_pattern.sv
// Pattern generator: word = seed ^ rotl(zero-extended address, PAT_ROT), optionally complemented.
// Purely combinational; no latency and no flow control.
module code_memory_bist_pattern
    import code_memory_bist_master_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              invert_i,
    output logic [DATA_W-1:0] word_o
);

    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] addr_rot;
    logic [DATA_W-1:0] raw_word;

    assign addr_ext = DATA_W'(addr_i);
    assign addr_rot = (addr_ext << PAT_ROT) | (addr_ext >> (DATA_W - PAT_ROT));
    assign raw_word = seed_i ^ addr_rot;
    assign word_o   = invert_i ? ~raw_word : raw_word;

endmodule

// File: rtl/code_memory_bist_master.sv
// Avalon-MM BIST master: writes a pattern over a word range, reads it back one word at a time and
// counts mismatches. Stalls on avm_waitrequest_i; 3*length busy cycles with no stalls and latency 1.
module code_memory_bist_master
    import code_memory_bist_master_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W:0]     length_i,
    input  logic [DATA_W-1:0]   seed_i,
    input  logic                invert_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ERR_W-1:0]    err_count_o,
    output logic [ADDR_W-1:0]   first_err_addr_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic                avm_chipselect_o,
    output logic                avm_write_o,
    output logic                avm_read_o,
    output logic [DATA_W/8-1:0] avm_byteenable_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    input  logic [DATA_W-1:0]   avm_readdata_i,
    input  logic                avm_waitrequest_i
);

    localparam int                BE_W     = DATA_W / 8;
    localparam int                LEN_W    = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [1:0]        LAT_INIT = 2'(READ_LATENCY - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   cur_q;
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    rem_q;
    logic [DATA_W-1:0]   seed_q;
    logic                inv_q;
    logic [1:0]          lat_q;
    logic [ERR_W-1:0]    err_q;
    logic [ADDR_W-1:0]   first_q;
    logic                cs_q;
    logic                wr_q;
    logic                rd_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W-1:0]   cur_d;
    logic [LEN_W-1:0]    rem_d;
    logic [LEN_W-1:0]    len_d;
    logic [ERR_W-1:0]    err_d;
    logic [DATA_W-1:0]   pat_word;
    logic                last_word;
    logic                xfer_ok;
    logic                mismatch;

    // One generator serves both paths: cur_q is the write address in WR and the compare address in RD_WAIT.
    code_memory_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .addr_i   (cur_q),
        .seed_i   (seed_q),
        .invert_i (inv_q),
        .word_o   (pat_word)
    );

    always_comb begin
        cur_d     = cur_q + ADDR_W'(1);
        rem_d     = rem_q - LEN_W'(1);
        len_d     = (length_i > LEN_MAX) ? LEN_MAX : length_i;
        err_d     = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
        last_word = (rem_q == LEN_W'(1));
        xfer_ok   = ~avm_waitrequest_i;
        mismatch  = (avm_readdata_i != pat_word);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            seed_q  <= '0;
            inv_q   <= 1'b0;
            lat_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            // Results are left as they are so a partial run can still be inspected.
            state_q <= ST_IDLE;
            cur_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q  <= base_addr_i;
                        cur_q   <= base_addr_i;
                        len_q   <= len_d;
                        rem_q   <= len_d;
                        seed_q  <= seed_i;
                        inv_q   <= invert_i;
                        err_q   <= '0;
                        first_q <= '0;
                        if (len_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WR;
                            busy_q  <= 1'b1;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (xfer_ok) begin
                        if (last_word) begin
                            state_q <= ST_RD_ISSUE;
                            cur_q   <= base_q;
                            rem_q   <= len_q;
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b1;
                        end else begin
                            cur_q <= cur_d;
                            rem_q <= rem_d;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    if (xfer_ok) begin
                        state_q <= ST_RD_WAIT;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        lat_q   <= LAT_INIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_q != 2'd0) begin
                        lat_q <= lat_q - 2'd1;
                    end else begin
                        // err_q can never return to zero once it counts, so zero marks the first miss.
                        if (mismatch) begin
                            err_q <= err_d;
                            if (err_q == '0) begin
                                first_q <= cur_q;
                            end
                        end
                        if (last_word) begin
                            state_q <= ST_DONE;
                            cur_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_ISSUE;
                            cur_q   <= cur_d;
                            rem_q   <= rem_d;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;
    assign avm_address_o    = cur_q;
    assign avm_chipselect_o = cs_q;
    assign avm_write_o      = wr_q;
    assign avm_read_o       = rd_q;
    assign avm_byteenable_o = {BE_W{cs_q}};
    assign avm_writedata_o  = wr_q ? pat_word : '0;

endmodule

// File: tb/tb_code_memory_bist_master.sv
// Bench for code_memory_bist_master: Avalon RAM model with fault/stall knobs, write/read address
// scoreboard queues and per-run expected results.
module tb_code_memory_bist_master;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [3:0]  err;
        logic [13:0] first;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] base_addr = '0;
    logic [14:0] length = '0;
    logic [31:0] seed = '0;
    logic        invert = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  err_count;
    logic [13:0] first_err_addr;
    logic [13:0] avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    wr_t         exp_wr[$];
    logic [13:0] exp_rd[$];
    res_t        exp_res[$];

    logic [31:0] mem [0:16383];
    logic        wait_mode = 1'b0;
    logic        rd_invert = 1'b0;
    logic [13:0] flip_addr = '0;
    logic [31:0] flip_mask = '0;
    logic        rd_acc = 1'b0;
    logic [31:0] rd_data = '0;
    int          extra_xfers = 0;
    int          cs_cycles = 0;

    always #5 clk = ~clk;

    code_memory_bist_master #(
        .ADDR_W       (14),
        .DATA_W       (32),
        .READ_LATENCY (1),
        .ERR_W        (4)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .start_i           (start),
        .abort_i           (abort),
        .base_addr_i       (base_addr),
        .length_i          (length),
        .seed_i            (seed),
        .invert_i          (invert),
        .busy_o            (busy),
        .done_o            (done),
        .err_count_o       (err_count),
        .first_err_addr_o  (first_err_addr),
        .avm_address_o     (avm_address),
        .avm_chipselect_o  (avm_chipselect),
        .avm_write_o       (avm_write),
        .avm_read_o        (avm_read),
        .avm_byteenable_o  (avm_byteenable),
        .avm_writedata_o   (avm_writedata),
        .avm_readdata_i    (avm_readdata),
        .avm_waitrequest_i (avm_waitrequest)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [13:0] a, input logic [31:0] s, input logic inv);
        logic [31:0] r;
        r = {11'b0, a, 7'b0};
        return inv ? ~(s ^ r) : (s ^ r);
    endfunction

    // RAM slave, evaluated mid-cycle: readdata for a read accepted on edge k is valid only before edge k+1.
    always @(negedge clk) begin
        avm_readdata = rd_acc ? rd_data : 32'hDEAD_BEEF;
        rd_acc = 1'b0;
        avm_waitrequest = wait_mode ? ~avm_waitrequest : 1'b0;
        if (avm_chipselect) cs_cycles++;
        if (avm_chipselect && !avm_waitrequest && !reset && !abort) begin
            check_eq("byteenable", avm_byteenable, 4'hF);
            if (avm_write) begin
                mem[avm_address] = avm_writedata;
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check_eq("wr_addr", avm_address, e.a);
                    check_eq("wr_data", avm_writedata, e.d);
                end else begin
                    extra_xfers++;
                end
            end
            if (avm_read) begin
                if (exp_rd.size() != 0) begin
                    logic [13:0] ea;
                    ea = exp_rd.pop_front();
                    check_eq("rd_addr", avm_address, ea);
                end else begin
                    extra_xfers++;
                end
                rd_data = mem[avm_address] ^ ((avm_address == flip_addr) ? flip_mask : 32'h0)
                          ^ (rd_invert ? 32'hFFFF_FFFF : 32'h0);
                rd_acc = 1'b1;
            end
        end
    end

    // exp_cyc: edges from the accepting edge until done is visible (-1 = not checked).
    task automatic run_test(input string name, input logic [13:0] base, input logic [14:0] len,
                            input logic [31:0] sd, input logic inv, input int exp_cyc,
                            input logic [3:0] exp_err, input logic [13:0] exp_first, input int restart_at);
        int   n;
        res_t r;
        for (int i = 0; i < int'(len); i++) begin
            logic [13:0] a;
            a = base + 14'(i);
            exp_wr.push_back('{a: a, d: pat(a, sd, inv)});
            exp_rd.push_back(a);
        end
        exp_res.push_back('{err: exp_err, first: exp_first});
        extra_xfers = 0;
        cs_cycles = 0;
        @(posedge clk); #1;
        base_addr = base; length = len; seed = sd; invert = inv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (len != 0) check_eq({name, ":busy_on"}, busy, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            if (n == restart_at) begin
                base_addr = base ^ 14'h0055; length = 15'd3; seed = ~sd; invert = ~inv; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check_eq({name, ":done_seen"}, done, 1'b1);
        if (exp_cyc >= 0) check_eq({name, ":done_cycles"}, n, exp_cyc);
        check_eq({name, ":busy_at_done"}, busy, 1'b0);
        r = exp_res.pop_front();
        check_eq({name, ":err_count"}, err_count, r.err);
        check_eq({name, ":first_err"}, first_err_addr, r.first);
        @(posedge clk); #1;
        check_eq({name, ":done_pulse_width"}, done, 1'b0);
        check_eq({name, ":err_hold"}, err_count, r.err);
        check_eq({name, ":wr_left"}, exp_wr.size(), 0);
        check_eq({name, ":rd_left"}, exp_rd.size(), 0);
        check_eq({name, ":extra_xfers"}, extra_xfers, 0);
    endtask

    initial begin
        int  n;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ctrl", {busy, done, err_count, first_err_addr, avm_chipselect, avm_write, avm_read,
                                avm_byteenable}, '0);
        check_eq("reset_bus", {avm_address, avm_writedata}, '0);
        reset = 1'b0;

        run_test("clean", 14'h0100, 15'd4, 32'hA5A5_0000, 1'b0, 12, 4'd0, 14'h0000, -1);

        flip_addr = 14'h0102; flip_mask = 32'h0000_0008;
        run_test("fault", 14'h0100, 15'd4, 32'hA5A5_0000, 1'b0, 12, 4'd1, 14'h0102, -1);
        flip_mask = '0;

        wait_mode = 1'b1;
        run_test("wrap_wait", 14'h3FFE, 15'd4, 32'h1234_5678, 1'b1, -1, 4'd0, 14'h0000, -1);
        wait_mode = 1'b0;

        run_test("zero_len", 14'h0200, 15'd0, 32'h0F0F_F0F0, 1'b0, 0, 4'd0, 14'h0000, -1);
        check_eq("zero_len:cs_cycles", cs_cycles, 0);

        run_test("restart", 14'h0300, 15'd20, 32'hCAFE_F00D, 1'b0, 60, 4'd0, 14'h0000, 5);

        // Abort while waiting on read data.
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back('{a: 14'h0500 + 14'(i), d: pat(14'h0500 + 14'(i), 32'h5555_AAAA, 1'b0)});
            exp_rd.push_back(14'h0500 + 14'(i));
        end
        @(posedge clk); #1;
        base_addr = 14'h0500; length = 15'd4; seed = 32'h5555_AAAA; invert = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(busy && !avm_chipselect) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("abort:reached_rd_wait", busy && !avm_chipselect, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort:cs", avm_chipselect, 1'b0);
        check_eq("abort:busy", busy, 1'b0);
        seen = done;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | done | avm_chipselect;
        end
        check_eq("abort:no_done_no_cs", seen, 1'b0);
        exp_wr.delete();
        exp_rd.delete();

        // Reset in the middle of the write phase.
        @(posedge clk); #1;
        base_addr = 14'h0600; length = 15'd8; seed = 32'h0BAD_CAFE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_mid:in_wr", avm_write, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("reset_mid:ctrl", {busy, done, err_count, first_err_addr, avm_chipselect, avm_write,
                                    avm_read, avm_byteenable}, '0);
        check_eq("reset_mid:bus", {avm_address, avm_writedata}, '0);
        reset = 1'b0;
        exp_wr.delete();
        exp_rd.delete();

        rd_invert = 1'b1;
        run_test("saturate", 14'h0400, 15'd32, 32'h8001_7FFE, 1'b0, 96, 4'd15, 14'h0400, -1);
        rd_invert = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/code_memory_bist_master.md
Name: code_memory_bist_master

Overview:
- Avalon-MM master (initiator) that drives the single-port on-chip code/data RAM slave: chipselect/write/byteenable/writedata out, readdata in.
- On `start`, writes a deterministic pattern over a word range, reads it back and compares each word, then reports the error count and the first failing address.
- Used for bring-up and production self-test of the Nios II program memory before the CPU is released from reset.

Parameters:
- ADDR_W, 14, word-address width; matches the slave address port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed cycles from an accepted read to valid readdata; legal range 1..3.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  returns the block to IDLE on the next edge.
- base_addr  in  ADDR_W  first word address of the test range.
- length  in  ADDR_W+1  number of words to test; 0 is legal.
- seed  in  DATA_W  pattern seed.
- invert  in  1  complements the pattern.
- busy  out  1  high from the cycle after `start` is accepted until the DONE state.
- done  out  1  one-cycle pulse at completion.
- err_count  out  ERR_W  mismatch count; saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  transfer request.
- avm_write  out  1  write qualifier.
- avm_read  out  1  read qualifier.
- avm_byteenable  out  DATA_W/8  always all-ones while chipselect is high; 0 otherwise.
- avm_writedata  out  DATA_W  pattern word.
- avm_readdata  in  DATA_W  slave read data.
- avm_waitrequest  in  1  slave stall; tie to 0 for on-chip RAM.

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared.
- Pattern: P(a) = seed ^ {zero-extended a, rotated left by 7}, complemented when `invert` = 1.
  - `seed` and `invert` are latched at start.
- States: IDLE -> WR -> RD_ISSUE -> RD_WAIT -> (RD_ISSUE | DONE) -> IDLE.
- IDLE:
  - On `start`, latch base_addr, length, seed and invert.
  - Clear err_count and first_err_addr.
  - If length = 0, go directly to DONE; otherwise go to WR.
- WR:
  - Drive chipselect = write = 1, address = cur, writedata = P(cur).
  - A transfer completes on any edge where waitrequest = 0; then advance cur and the word count.
  - After the last word, set cur = base and go to RD_ISSUE.
- RD_ISSUE:
  - Drive chipselect = read = 1, address = cur.
  - On acceptance (waitrequest = 0), go to RD_WAIT.
  - Only one read is outstanding at a time.
- RD_WAIT:
  - Wait READ_LATENCY cycles after acceptance, counting the acceptance edge as the first.
  - Compare avm_readdata with P(cur) at the edge that ends the wait.
  - On mismatch: increment err_count, saturating at 2^ERR_W-1. If this is the first mismatch, capture first_err_addr = cur.
  - Then go to RD_ISSUE for the next word, or to DONE after the last.
- DONE: assert done for one cycle; busy = 0; go to IDLE. err_count and first_err_addr hold until the next accepted start.
- Address arithmetic is modulo 2^ADDR_W; a range crossing the top wraps to 0.
- Lengths above 2^ADDR_W are clamped to 2^ADDR_W.
- `start` while busy is ignored.
- `abort` has priority over every state transition: next state IDLE, bus outputs drop immediately, no done pulse. Result registers hold partial values.
- Synchronous reset mid-operation behaves like abort, and additionally clears the results.
- Throughput with waitrequest = 0 and READ_LATENCY = 1: 1 cycle per written word, 2 cycles per read word. Total busy cycles = length + 2*length.

Decomposition:
- Shared include/package holds:
  - state encoding constants: IDLE = 0, WR = 1, RD_ISSUE = 2, RD_WAIT = 3, DONE = 4;
  - the pattern rotation constant, 7.
- One combinational sub-module, code_memory_bist_pattern (address, seed, invert -> word), is instantiated once and shared by the write and compare paths.
- The FSM, counters and result registers stay in the top module.

Test Plan:
- Clean pass: base = 0x0100, length = 4, seed = 0xA5A5_0000, invert = 0, zero-wait RAM model with latency 1 -> four writes on consecutive cycles; done pulses exactly 12 cycles after start is accepted; err_count = 0.
- Fault injection: RAM model flips bit 3 of the word at 0x0102 -> err_count = 1, first_err_addr = 0x0102; done still pulses.
- Wrap and waitrequest:
  - Setup: base = 0x3FFE, length = 4, waitrequest high every other cycle.
  - Required addresses: 0x3FFE, 0x3FFF, 0x0000, 0x0001.
  - Required: no transfer is lost or duplicated, and err_count = 0.
- Zero length and ignored start: length = 0 -> done on the second cycle after start with no chipselect ever asserted; a second start pulse while busy in a long run has no effect.
- Abort and reset: abort asserted during RD_WAIT -> chipselect = 0 and state IDLE on the next cycle, with no done pulse. Reset asserted mid-WR -> all outputs 0 on the next cycle.
- Saturation: ERR_W = 4, RAM model returns an inverted pattern, length = 32 -> err_count = 15, first_err_addr = base.
